mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
Multi-cycle control sequencer for the processor datapath: PC register, instruction memory, register file, ALU and data memory.
- Replaces the single-cycle control ROM with a registered FSM.
- Steps each instruction through fetch/decode/execute/memory/writeback.
- Waits on ready/ack handshakes from instruction and data memory.
- Drives the same datapath select/enable lines, plus performance counters and halt/trap status.

Parameters:
CNT_W, 32, width of retired-instruction and cycle counters
WAIT_MAX, 16, max cycles a memory request may wait for ack before timeout trap (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
run  in  1  start pulse; sampled only in IDLE
instr  in  32  current IR contents (opcode [31:26], funct [5:0])
alu_eq  in  1  ALU equality flag
imem_ack  in  1  instruction word valid this cycle
dmem_ack  in  1  data access complete this cycle
imem_req  out  1  instruction fetch request
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
ir_we  out  1  latch instruction register
pc_we  out  1  update PC
pc_src  out  1  0 = PC+1, 1 = PC+1+signext
reg_we  out  1  register file write enable
reg_dst  out  1  1 = rd [15:11], 0 = rt [20:16]
mem_to_reg  out  1  1 = data memory, 0 = ALU to write data
alu_src  out  1  1 = sign-extended immediate, 0 = register
alu_op  out  1  0 = add, 1 = sub
busy  out  1  FSM outside IDLE/HALT
halted  out  1  in HALT
illegal  out  1  sticky, halt caused by unknown opcode
timeout  out  1  sticky, halt caused by ack timeout
retired_cnt  out  CNT_W  instructions completed
cycle_cnt  out  CNT_W  cycles spent busy

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counters 0, wait counter 0. Pending requests drop immediately, also mid-instruction.
- Registered: state, wait counter, sticky flags, counters. Control outputs: combinational from state + instr opcode (+ ack/alu_eq where noted).
- Opcodes:
  - RTYPE 000000: alu_op = funct[1]
  - ADDI 001000
  - LW 100011
  - SW 101011
  - BEQ 000100
  - HALT 111111
  - anything else is illegal.
- IDLE: run=1 -> FETCH. Otherwise stay.
- FETCH:
  - imem_req=1 held until imem_ack.
  - ir_we=imem_ack (same cycle).
  - On ack -> DECODE; same-cycle ack is legal (1-cycle fetch).
- DECODE:
  - HALT -> HALT.
  - Illegal -> HALT, illegal<=1.
  - Else -> EXEC.
- EXEC:
  - alu_src=1 for ADDI/LW/SW, else 0; alu_op=1 for BEQ.
  - BEQ: pc_we=1, pc_src=alu_eq, retire -> FETCH.
  - RTYPE/ADDI -> WB. LW/SW -> MEM.
- MEM:
  - dmem_req=1, dmem_we=(SW), alu_src=1 held until dmem_ack.
  - On ack: SW gives pc_we=1, pc_src=0, retire -> FETCH. LW -> WB.
- WB:
  - reg_we=1, reg_dst=(RTYPE), mem_to_reg=(LW), alu_src/alu_op as in EXEC.
  - pc_we=1, pc_src=0, retire -> FETCH.
- HALT: halted=1, busy=0. Stays until reset; run ignored.
- Timeout:
  - Wait counter clears on entering FETCH/MEM and increments per un-acked cycle.
  - Reaching WAIT_MAX without ack -> HALT, timeout<=1, request drops next cycle.
  - Ack in the WAIT_MAX-th cycle wins over timeout.
- Latency with zero-wait acks: BEQ 3 cycles, RTYPE/ADDI/SW 4, LW 5. Each memory wait cycle adds 1.
- retired_cnt: +1 on each retire. cycle_cnt: +1 each cycle busy=1. Both saturate at all-ones, no wrap.
- run mid-instruction is ignored. instr must stay stable from ir_we until the next FETCH (IR owned by datapath).

Decomposition:
- Shared package mc_pkg: opcode constants, state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; 3 bits), funct constants, control-field bit positions.
- One sub-module, mc_opclass: combinational instr -> {is_rtype, is_addi, is_lw, is_sw, is_beq, is_halt, is_illegal}.
- Rest in mc_sequencer.

Test Plan:
1. Reset, run pulse, instr=0x00221820 (add), acks tied 1 -> FETCH/DECODE/EXEC/WB. In WB cycle 4: reg_we=1, reg_dst=1, mem_to_reg=0, pc_we=1, pc_src=0. retired_cnt=1, cycle_cnt=4.
2. instr=0x8C220004 (LW), dmem_ack delayed 3 cycles -> dmem_req=1 for 4 cycles, dmem_we=0, alu_src=1. WB has mem_to_reg=1, reg_dst=0. Total 8 cycles.
3. instr=0x10220003 (BEQ):
   - alu_eq=1 -> EXEC pc_we=1, pc_src=1, alu_op=1, no reg_we, 3 cycles.
   - Repeat with alu_eq=0 -> pc_src=0.
4. instr=0xFC000000 (HALT) -> halted=1, busy=0 from cycle 3. Later run pulses ignored; retired_cnt unchanged.
5. WAIT_MAX=8, imem_ack held 0 -> imem_req high 8 cycles, then halted=1, timeout=1, imem_req=0.
   - Also: ack on 8th cycle -> normal DECODE, timeout=0.
6. instr=0xAC220000 (SW) with rst=0 mid-MEM -> all outputs 0 immediately, state IDLE, counters 0.
   - Also: instr=0x3C000000 -> illegal=1, halted=1 after DECODE.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control sequencer.
// Holds the instruction field positions, opcode/funct constants, the FSM state
// encoding and the decoded opcode-class record passed from mc_opclass to the top.
package mc_pkg;

    localparam int unsigned InstrW      = 32;
    localparam int unsigned OpMsb       = 31;
    localparam int unsigned OpLsb       = 26;
    localparam int unsigned FunctSubBit = 1;   // funct[1]: 0 = add, 1 = sub

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpHalt  = 6'b111111;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    typedef struct packed {
        logic is_rtype;
        logic is_addi;
        logic is_lw;
        logic is_sw;
        logic is_beq;
        logic is_halt;
        logic is_illegal;
    } opclass_t;

    function automatic logic [5:0] get_opcode(input logic [InstrW-1:0] instr);
        return instr[OpMsb:OpLsb];
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// mc_sequencer_if: datapath/memory-side bundle of the control sequencer.
//   master : sequencer side - takes run, IR contents, ALU flag, memory acks;
//            drives memory requests, datapath selects/enables, status, counters.
//   slave  : datapath/environment side (mirror directions).
interface mc_sequencer_if
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic              run;
    logic [InstrW-1:0] instr;
    logic              alu_eq;
    logic              imem_ack;
    logic              dmem_ack;

    logic              imem_req;
    logic              dmem_req;
    logic              dmem_we;
    logic              ir_we;
    logic              pc_we;
    logic              pc_src;
    logic              reg_we;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              alu_src;
    logic              alu_op;
    logic              busy;
    logic              halted;
    logic              illegal;
    logic              timeout;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        input  run, instr, alu_eq, imem_ack, dmem_ack,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src, alu_op, busy, halted, illegal, timeout,
               retired_cnt, cycle_cnt
    );

    modport slave (
        output run, instr, alu_eq, imem_ack, dmem_ack,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src, alu_op, busy, halted, illegal, timeout,
               retired_cnt, cycle_cnt
    );
endinterface

// File: rtl/mc_opclass.sv
// mc_opclass: combinational opcode classifier.
//   i_opcode : instruction opcode field
//   o_class  : one-hot class {rtype, addi, lw, sw, beq, halt, illegal}
module mc_opclass
    import mc_pkg::*;
(
    input  logic [5:0] i_opcode,
    output opclass_t   o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OpRtype: o_class.is_rtype   = 1'b1;
            OpAddi:  o_class.is_addi    = 1'b1;
            OpLw:    o_class.is_lw      = 1'b1;
            OpSw:    o_class.is_sw      = 1'b1;
            OpBeq:   o_class.is_beq     = 1'b1;
            OpHalt:  o_class.is_halt    = 1'b1;
            default: o_class.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control FSM for the PC/IR/regfile/ALU/dmem datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on memory acks
// with a bounded wait counter, and keeps retired/busy-cycle counters and sticky
// halt-cause flags.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   io_bus  : mc_sequencer_if master (handshakes, datapath controls, status)
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mc_sequencer_if.master io_bus
);

    localparam int unsigned     WaitW    = $clog2(WAIT_MAX + 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [WaitW-1:0] r_wait;
    logic [WaitW-1:0] w_wait_next;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] r_cycles;

    logic             w_set_illegal;
    logic             w_set_timeout;
    logic             w_retire;
    logic             w_busy;
    logic             w_alu_src_x;
    logic             w_alu_op_x;
    opclass_t         w_class;
    logic             w_unused_instr;

    mc_opclass u_opclass (
        .i_opcode (get_opcode(io_bus.instr)),
        .o_class  (w_class)
    );

    // Only the opcode and funct[1] steer control; the rest belongs to the datapath.
    assign w_unused_instr = ^{io_bus.instr[25:2], io_bus.instr[0]};

    // ALU selects shared by EXEC and WB.
    assign w_alu_src_x = w_class.is_addi | w_class.is_lw | w_class.is_sw;
    assign w_alu_op_x  = w_class.is_beq | (w_class.is_rtype & io_bus.instr[FunctSubBit]);

    assign w_busy = (r_state != StIdle) && (r_state != StHalt);

    always_comb begin
        w_state_next      = r_state;
        w_wait_next       = '0;   // wait counter only survives while stalled
        w_set_illegal     = 1'b0;
        w_set_timeout     = 1'b0;
        w_retire          = 1'b0;
        io_bus.imem_req   = 1'b0;
        io_bus.dmem_req   = 1'b0;
        io_bus.dmem_we    = 1'b0;
        io_bus.ir_we      = 1'b0;
        io_bus.pc_we      = 1'b0;
        io_bus.pc_src     = 1'b0;
        io_bus.reg_we     = 1'b0;
        io_bus.reg_dst    = 1'b0;
        io_bus.mem_to_reg = 1'b0;
        io_bus.alu_src    = 1'b0;
        io_bus.alu_op     = 1'b0;

        case (r_state)
            StIdle: begin
                if (io_bus.run) w_state_next = StFetch;
            end
            StFetch: begin
                io_bus.imem_req = 1'b1;
                io_bus.ir_we    = io_bus.imem_ack;
                if (io_bus.imem_ack) begin
                    w_state_next = StDecode;
                end else if (r_wait == WaitLast) begin
                    w_state_next  = StHalt;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            StDecode: begin
                if (w_class.is_halt) begin
                    w_state_next = StHalt;
                end else if (w_class.is_illegal) begin
                    w_state_next  = StHalt;
                    w_set_illegal = 1'b1;
                end else begin
                    w_state_next = StExec;
                end
            end
            StExec: begin
                io_bus.alu_src = w_alu_src_x;
                io_bus.alu_op  = w_alu_op_x;
                if (w_class.is_beq) begin
                    io_bus.pc_we  = 1'b1;
                    io_bus.pc_src = io_bus.alu_eq;
                    w_retire      = 1'b1;
                    w_state_next  = StFetch;
                end else if (w_class.is_lw || w_class.is_sw) begin
                    w_state_next = StMem;
                end else begin
                    w_state_next = StWb;
                end
            end
            StMem: begin
                io_bus.dmem_req = 1'b1;
                io_bus.dmem_we  = w_class.is_sw;
                io_bus.alu_src  = 1'b1;
                if (io_bus.dmem_ack) begin
                    if (w_class.is_sw) begin
                        io_bus.pc_we = 1'b1;
                        w_retire     = 1'b1;
                        w_state_next = StFetch;
                    end else begin
                        w_state_next = StWb;
                    end
                end else if (r_wait == WaitLast) begin
                    w_state_next  = StHalt;
                    w_set_timeout = 1'b1;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            StWb: begin
                io_bus.reg_we     = 1'b1;
                io_bus.reg_dst    = w_class.is_rtype;
                io_bus.mem_to_reg = w_class.is_lw;
                io_bus.alu_src    = w_alu_src_x;
                io_bus.alu_op     = w_alu_op_x;
                io_bus.pc_we      = 1'b1;
                w_retire          = 1'b1;
                w_state_next      = StFetch;
            end
            StHalt: begin
                w_state_next = StHalt;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= StIdle;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_retired <= '0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            if (w_set_illegal) r_illegal <= 1'b1;
            if (w_set_timeout) r_timeout <= 1'b1;
            // Both counters saturate at all-ones.
            if (w_retire && (r_retired != '1)) r_retired <= r_retired + 1'b1;
            if (w_busy && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
        end
    end

    assign io_bus.busy        = w_busy;
    assign io_bus.halted      = (r_state == StHalt);
    assign io_bus.illegal     = r_illegal;
    assign io_bus.timeout     = r_timeout;
    assign io_bus.retired_cnt = r_retired;
    assign io_bus.cycle_cnt   = r_cycles;

endmodule
